// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: parametrised GPIO bank behind the PS register bridge.
// Each pin gets an input synchroniser, an optional debounce filter,
// edge-selectable sticky interrupt status (write-1-to-clear), an atomic
// output toggle, and a registered level IRQ.
//
// Ports:
//   sysclk     - system clock, rising edge
//   rst        - synchronous reset, active-high
//   reg_wr     - single-cycle write strobe
//   reg_rd     - single-cycle read strobe
//   reg_addr   - register index (0 OUT, 1 OUTEN, 2 IN, 3 IRQ_EN,
//                4 RISE_SEL, 5 FALL_SEL, 6 STATUS, 7 TOGGLE)
//   reg_wdata  - write data
//   reg_rdata  - read data, registered, valid the cycle after reg_rd
//   pin_out    - pad output values
//   pin_oe     - pad output enables, 1 = drive
//   pin_in     - raw asynchronous pad values
//   irq        - registered level interrupt
module gpio_bank_ctrl #(
    parameter int unsigned N_PINS       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [2:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic [N_PINS-1:0] pin_out,
    output logic [N_PINS-1:0] pin_oe,
    input  logic [N_PINS-1:0] pin_in,
    output logic              irq
);

    localparam logic [2:0] ADDR_OUT    = 3'd0;
    localparam logic [2:0] ADDR_OUTEN  = 3'd1;
    localparam logic [2:0] ADDR_IN     = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd3;
    localparam logic [2:0] ADDR_RISE   = 3'd4;
    localparam logic [2:0] ADDR_FALL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;
    localparam logic [2:0] ADDR_TOGGLE = 3'd7;

    localparam int unsigned PRIME_CYC = SYNC_STAGES + 2;
    localparam int unsigned PRIME_W   = $clog2(PRIME_CYC + 1);

    logic [N_PINS-1:0] out_q, oe_q, ien_q, rsel_q, fsel_q, status_q;
    logic [N_PINS-1:0] filt_q, filt_d_q;
    logic [N_PINS-1:0] sync_q [SYNC_STAGES];
    logic [PRIME_W-1:0] prime_q;

    logic [N_PINS-1:0] wdata_c, w1c_c, s_c, rise_c, fall_c, evt_c;
    logic              primed_c;
    logic [31:0]       rd_mux_c;
    logic              unused_wdata;

    // Bits above N_PINS are not stored anywhere.
    assign unused_wdata = ^reg_wdata;
    assign wdata_c      = reg_wdata[N_PINS-1:0];
    assign w1c_c        = (reg_wr && reg_addr == ADDR_STATUS) ? wdata_c : '0;

    assign pin_out = out_q;
    assign pin_oe  = oe_q;

    // Input synchroniser chain; s_c is the last stage.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign s_c = sync_q[SYNC_STAGES-1];

    // Input filter: bypass, or per-pin debounce counter.
    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            always_ff @(posedge sysclk) begin
                if (rst) filt_q <= '0;
                else     filt_q <= s_c;
            end
        end else begin : g_debounce
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
            logic [CNT_W-1:0] cnt_q [N_PINS];

            // A change is accepted once it has differed from filt for DEBOUNCE_CYC cycles.
            always_ff @(posedge sysclk) begin
                for (int i = 0; i < int'(N_PINS); i++) begin
                    if (rst) begin
                        cnt_q[i]  <= '0;
                        filt_q[i] <= 1'b0;
                    end else if (s_c[i] == filt_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        filt_q[i] <= s_c[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Priming window keeps pins that are already high at reset from raising events.
    always_ff @(posedge sysclk) begin
        if (rst)            prime_q <= '0;
        else if (!primed_c) prime_q <= prime_q + PRIME_W'(1);
    end
    assign primed_c = (prime_q == PRIME_W'(PRIME_CYC));

    assign rise_c = filt_q & ~filt_d_q;
    assign fall_c = ~filt_q & filt_d_q;
    assign evt_c  = primed_c ? ((rise_c & rsel_q) | (fall_c & fsel_q)) : '0;

    // Edge history, sticky status (set beats clear) and IRQ.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            filt_d_q <= '0;
            status_q <= '0;
            irq      <= 1'b0;
        end else begin
            filt_d_q <= filt_q;
            status_q <= (status_q & ~w1c_c) | evt_c;
            irq      <= |(status_q & ien_q);
        end
    end

    // Control register writes.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            out_q  <= '0;
            oe_q   <= '0;
            ien_q  <= '0;
            rsel_q <= '0;
            fsel_q <= '0;
        end else if (reg_wr) begin
            case (reg_addr)
                ADDR_OUT:    out_q  <= wdata_c;
                ADDR_OUTEN:  oe_q   <= wdata_c;
                ADDR_IRQ_EN: ien_q  <= wdata_c;
                ADDR_RISE:   rsel_q <= wdata_c;
                ADDR_FALL:   fsel_q <= wdata_c;
                ADDR_TOGGLE: out_q  <= out_q ^ wdata_c;
                default:     ;
            endcase
        end
    end

    // Read mux sees pre-write register values.
    always_comb begin
        rd_mux_c = '0;
        case (reg_addr)
            ADDR_OUT:    rd_mux_c = 32'(out_q);
            ADDR_OUTEN:  rd_mux_c = 32'(oe_q);
            ADDR_IN:     rd_mux_c = 32'(filt_q);
            ADDR_IRQ_EN: rd_mux_c = 32'(ien_q);
            ADDR_RISE:   rd_mux_c = 32'(rsel_q);
            ADDR_FALL:   rd_mux_c = 32'(fsel_q);
            ADDR_STATUS: rd_mux_c = 32'(status_q);
            default:     rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst)         reg_rdata <= '0;
        else if (reg_rd) reg_rdata <= rd_mux_c;
    end

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
module tb_gpio_bank_ctrl;

    localparam int NA = 4;
    localparam int SA = 2;
    localparam int DA = 0;
    localparam int NB = 32;
    localparam int SB = 3;
    localparam int DB = 8;

    logic        sysclk = 1'b0;
    logic        rst, reg_wr, reg_rd;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] rdata_a, rdata_b;
    logic [NA-1:0] out_a, oe_a, pin_a;
    logic [NB-1:0] out_b, oe_b, pin_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    gpio_bank_ctrl #(.N_PINS(NA), .SYNC_STAGES(SA), .DEBOUNCE_CYC(DA)) u_dut_a (
        .sysclk(sysclk), .rst(rst), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_a),
        .pin_out(out_a), .pin_oe(oe_a), .pin_in(pin_a), .irq(irq_a));

    gpio_bank_ctrl #(.N_PINS(NB), .SYNC_STAGES(SB), .DEBOUNCE_CYC(DB)) u_dut_b (
        .sysclk(sysclk), .rst(rst), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_b),
        .pin_out(out_b), .pin_oe(oe_b), .pin_in(pin_b), .irq(irq_b));

    // ---------------- reference model (history based) ----------------
    logic [31:0] m_out[2], m_oe[2], m_ien[2], m_rsel[2], m_fsel[2];
    logic [31:0] m_st[2], m_filt[2], m_filtd[2], m_rd[2];
    logic        m_irq[2];
    int          m_n[2];
    logic [31:0] m_ph[2][16];   // raw pin samples, [0] = newest
    logic [31:0] m_sh[2][16];   // synchronised values seen at each edge

    function automatic int p_np(input int d);  return (d == 0) ? NA : NB; endfunction
    function automatic int p_s(input int d);   return (d == 0) ? SA : SB; endfunction
    function automatic int p_d(input int d);   return (d == 0) ? DA : DB; endfunction
    function automatic logic [31:0] p_mask(input int d);
        return (p_np(d) >= 32) ? 32'hFFFF_FFFF : ((32'd1 << p_np(d)) - 32'd1);
    endfunction

    task automatic model_step(input int d, input logic [31:0] pin);
        logic [31:0] msk, wd, w1c, rise, fall, evt, s_old;
        logic stable;
        int ns, nd;
        msk = p_mask(d);
        ns  = p_s(d);
        nd  = p_d(d);
        if (rst) begin
            m_out[d] = '0; m_oe[d] = '0; m_ien[d] = '0; m_rsel[d] = '0; m_fsel[d] = '0;
            m_st[d] = '0; m_filt[d] = '0; m_filtd[d] = '0; m_rd[d] = '0; m_irq[d] = 1'b0;
            m_n[d] = 0;
            for (int j = 0; j < 16; j++) begin
                m_ph[d][j] = '0;
                m_sh[d][j] = '0;
            end
        end else begin
            wd  = reg_wdata & msk;
            w1c = (reg_wr && reg_addr == 3'd6) ? wd : '0;
            if (reg_rd) begin
                case (reg_addr)
                    3'd0: m_rd[d] = m_out[d];
                    3'd1: m_rd[d] = m_oe[d];
                    3'd2: m_rd[d] = m_filt[d];
                    3'd3: m_rd[d] = m_ien[d];
                    3'd4: m_rd[d] = m_rsel[d];
                    3'd5: m_rd[d] = m_fsel[d];
                    3'd6: m_rd[d] = m_st[d];
                    default: m_rd[d] = '0;
                endcase
            end
            rise = m_filt[d] & ~m_filtd[d];
            fall = ~m_filt[d] & m_filtd[d];
            evt  = (m_n[d] >= ns + 2) ? ((rise & m_rsel[d]) | (fall & m_fsel[d])) : '0;
            m_irq[d] = |(m_st[d] & m_ien[d]);
            m_st[d]  = (m_st[d] & ~w1c) | evt;
            if (reg_wr) begin
                case (reg_addr)
                    3'd0: m_out[d]  = wd;
                    3'd1: m_oe[d]   = wd;
                    3'd3: m_ien[d]  = wd;
                    3'd4: m_rsel[d] = wd;
                    3'd5: m_fsel[d] = wd;
                    3'd7: m_out[d]  = m_out[d] ^ wd;
                    default: ;
                endcase
            end
            // Synchronised value = raw sample taken SYNC_STAGES-1 edges ago.
            s_old = m_ph[d][ns-1];
            for (int j = 15; j > 0; j--) m_sh[d][j] = m_sh[d][j-1];
            m_sh[d][0] = s_old;
            m_filtd[d] = m_filt[d];
            if (nd == 0) begin
                m_filt[d] = s_old;
            end else begin
                // Flip a pin once its last nd synchronised values all disagree with it.
                for (int i = 0; i < 32; i++) begin
                    if (msk[i]) begin
                        stable = 1'b1;
                        for (int j = 0; j < nd; j++)
                            if (m_sh[d][j][i] == m_filt[d][i]) stable = 1'b0;
                        if (stable) m_filt[d][i] = ~m_filt[d][i];
                    end
                end
            end
            for (int j = 15; j > 0; j--) m_ph[d][j] = m_ph[d][j-1];
            m_ph[d][0] = pin & msk;
            if (m_n[d] < 1000) m_n[d]++;
        end
    endtask

    always @(posedge sysclk) begin
        model_step(0, 32'(pin_a));
        model_step(1, pin_b);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        cyc();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        reg_rd = 1'b1; reg_addr = a;
        cyc();
        reg_rd = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  out_a;
        logic [3:0]  oe_a;
        logic [31:0] rd_a;
        logic [31:0] rd_b;
    } vec_t;

    vec_t tbl[13];
    int   first;

    initial begin
        rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        pin_a = 4'hF; pin_b = '0;

        // Reset with pins high, select rising edges during priming.
        repeat (3) cyc();
        chk("rst_pin_out", 32'(out_a), 32'h0);
        chk("rst_pin_oe", 32'(oe_a), 32'h0);
        chk("rst_rdata", rdata_a, 32'h0);
        chk("rst_irq", 32'(irq_a), 32'h0);
        rst = 1'b0;
        wr(3'd4, 32'h0000_000F);
        repeat (8) cyc();
        rd(3'd6);
        chk("prime_status_a", rdata_a, 32'h0);
        chk("prime_status_b", rdata_b, 32'h0);
        rd(3'd2);
        chk("prime_in_a", rdata_a, 32'h0000_000F);
        chk("prime_in_b", rdata_b, 32'h0);

        // Register table.
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h5,         4'h5, 4'h0, 32'hF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd7, 32'h3,         4'h6, 4'h0, 32'hF, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'd1, 32'hA,         4'h6, 4'hA, 32'hF, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'h0,         4'h6, 4'hA, 32'hA, 32'hA};
        tbl[4]  = '{1'b0, 1'b1, 3'd0, 32'h0,         4'h6, 4'hA, 32'h6, 32'h6};
        tbl[5]  = '{1'b0, 1'b1, 3'd7, 32'h0,         4'h6, 4'hA, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 3'd2, 32'h0,         4'h6, 4'hA, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'd2, 32'h0,         4'h6, 4'hA, 32'hF, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 4'h6, 4'hA, 32'hF, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'd3, 32'h0,         4'h6, 4'hA, 32'hF, 32'hFFFF_FFFF};
        tbl[10] = '{1'b1, 1'b1, 3'd0, 32'h9,         4'h9, 4'hA, 32'h6, 32'h6};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 32'h0,         4'h9, 4'hA, 32'h9, 32'h9};
        tbl[12] = '{1'b1, 1'b0, 3'd3, 32'h1,         4'h9, 4'hA, 32'h9, 32'h9};
        for (int i = 0; i < 13; i++) begin
            reg_wr = tbl[i].wr; reg_rd = tbl[i].rd;
            reg_addr = tbl[i].addr; reg_wdata = tbl[i].wdata;
            cyc();
            reg_wr = 1'b0; reg_rd = 1'b0;
            chk($sformatf("tbl%0d_out", i), 32'(out_a), 32'(tbl[i].out_a));
            chk($sformatf("tbl%0d_oe", i), 32'(oe_a), 32'(tbl[i].oe_a));
            chk($sformatf("tbl%0d_rd_a", i), rdata_a, tbl[i].rd_a);
            chk($sformatf("tbl%0d_rd_b", i), rdata_b, tbl[i].rd_b);
        end

        // Rising edge on pin 0 -> STATUS at k+3, irq at k+4; W1C drops irq.
        pin_a = 4'h0;
        repeat (6) cyc();
        wr(3'd6, 32'hFFFF_FFFF);
        pin_a = 4'h1;
        repeat (3) cyc();
        reg_rd = 1'b1; reg_addr = 3'd6;
        cyc();
        chk("rise_status_k3", rdata_a, 32'h0);
        chk("rise_irq_k3", 32'(irq_a), 32'h0);
        cyc();
        reg_rd = 1'b0;
        chk("rise_status_k4", rdata_a, 32'h1);
        chk("rise_irq_k4", 32'(irq_a), 32'h1);
        wr(3'd6, 32'h1);
        chk("w1c_irq_hold", 32'(irq_a), 32'h1);
        cyc();
        chk("w1c_irq_low", 32'(irq_a), 32'h0);
        rd(3'd6);
        chk("w1c_status", rdata_a, 32'h0);

        // Fall event on pin 1 and W1C of bit 1 in the same cycle: set wins.
        wr(3'd5, 32'h2);
        pin_a = 4'h3;
        repeat (6) cyc();
        wr(3'd6, 32'hF);
        pin_a = 4'h1;
        repeat (3) cyc();
        reg_wr = 1'b1; reg_addr = 3'd6; reg_wdata = 32'h2;
        cyc();
        reg_wr = 1'b0;
        rd(3'd6);
        chk("race_set_wins", rdata_a, 32'h2);
        wr(3'd6, 32'h2);
        rd(3'd6);
        chk("race_clear_later", rdata_a, 32'h0);

        // Debounce on the wide instance: short glitch dropped, long pulse accepted.
        wr(3'd6, 32'hFFFF_FFFF);
        pin_b[2] = 1'b1;
        repeat (5) cyc();
        pin_b[2] = 1'b0;
        repeat (20) cyc();
        rd(3'd2);
        chk("glitch_in", rdata_b, 32'h0);
        rd(3'd6);
        chk("glitch_status", rdata_b, 32'h0);
        first = -1;
        pin_b[2] = 1'b1;
        reg_rd = 1'b1; reg_addr = 3'd2;
        for (int j = 1; j <= 30; j++) begin
            cyc();
            if (rdata_b[2] && first < 0) first = j;
            if (j == 12) pin_b[2] = 1'b0;
        end
        reg_rd = 1'b0;
        chk("deb_in_latency", 32'(first), 32'd12);
        rd(3'd6);
        chk("deb_status", rdata_b, 32'h4);

        // Full-width toggle and independent status on pins 31 and 0.
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        chk("wide_toggle_b", out_b, 32'h0);
        chk("wide_toggle_a", 32'(out_a), 32'h0);
        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        pin_b[31] = 1'b1;
        repeat (16) cyc();
        rd(3'd6);
        chk("wide_pin31", rdata_b, 32'h8000_0000);
        pin_b[0] = 1'b1;
        repeat (16) cyc();
        rd(3'd6);
        chk("wide_pin31_0", rdata_b, 32'h8000_0001);
        wr(3'd6, 32'h8000_0000);
        rd(3'd6);
        chk("wide_clear31", rdata_b, 32'h0000_0001);

        // Randomised traffic against the model, with occasional mid-run resets.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            reg_wr    = !rst && ($urandom_range(0, 3) == 0);
            reg_rd    = ($urandom_range(0, 1) == 1);
            reg_addr  = 3'($urandom_range(0, 7));
            reg_wdata = $urandom;
            if (reg_addr == 3'd6) reg_wdata = reg_wdata & $urandom;
            for (int i = 0; i < NA; i++)
                if ($urandom_range(0, 11) == 0) pin_a[i] = ~pin_a[i];
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 19) == 0) pin_b[i] = ~pin_b[i];
            cyc();
            chk("rnd_rdata_a", rdata_a, m_rd[0]);
            chk("rnd_rdata_b", rdata_b, m_rd[1]);
            chk("rnd_out_a", 32'(out_a), m_out[0]);
            chk("rnd_out_b", out_b, m_out[1]);
            chk("rnd_oe_a", 32'(oe_a), m_oe[0]);
            chk("rnd_oe_b", oe_b, m_oe[1]);
            chk("rnd_irq_a", 32'(irq_a), 32'(m_irq[0]));
            chk("rnd_irq_b", 32'(irq_b), 32'(m_irq[1]));
        end
        rst = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
